// File: rtl/vsdmem_pkg.sv
// Shared types and constants for the Wishbone SRAM bridge.
package vsdmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_WR,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_WRERR   = 1;
    localparam int CTRL_LAT_LSB = 8;

    // The control register lives just above the SRAM word space.
    function automatic int ctrl_sel_bit(input int aw);
        return aw;
    endfunction

    function automatic bit read_lat_ok(input int lat);
        return (lat >= 1) && (lat <= 4);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Purpose: valid shift register that flags when an issued SRAM read has data on dout.
// Latency: done asserts READ_LAT cycles after the cycle chip select was low.
// Backpressure: none; one strobe per issued read, reads never stall.
module sram_rd_pipe #(
    parameter int READ_LAT = 1
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic issue,
    output logic done
);

    logic [READ_LAT-1:0] vld_sr;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign done = vld_sr[READ_LAT-1];

endmodule

// File: rtl/wb_sram_bridge.sv
// Purpose: Wishbone-classic slave sharing a 1RW+1R SRAM with the core fetch port.
// Latency: ctrl/err ack in c1, writes in c2, reads in c2+READ_LAT.
// Backpressure: one transaction at a time; new requests wait in IDLE until ack drops.
module wb_sram_bridge
    import vsdmem_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int READ_LAT = 1,
    parameter bit RUN_RST  = 1'b0
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [DW/8-1:0] wbs_sel_i,
    input  logic [AW:0]     wbs_adr_i,
    input  logic [DW-1:0]   wbs_dat_i,
    output logic            wbs_ack_o,
    output logic            wbs_err_o,
    output logic [DW-1:0]   wbs_dat_o,
    output logic            core_rst_o,
    input  logic [AW-1:0]   core_addr_i,
    output logic [DW-1:0]   core_data_o,
    output logic            sram_csb0_o,
    output logic            sram_web0_o,
    output logic [DW/8-1:0] sram_wmask0_o,
    output logic [AW-1:0]   sram_addr0_o,
    output logic [DW-1:0]   sram_din0_o,
    input  logic [DW-1:0]   sram_dout0_i,
    output logic            sram_csb1_o,
    output logic [AW-1:0]   sram_addr1_o,
    input  logic [DW-1:0]   sram_dout1_i
);

    localparam int CTRL_SEL = ctrl_sel_bit(AW);

    if (!read_lat_ok(READ_LAT)) begin : g_lat_chk
        $error("wb_sram_bridge: READ_LAT must be 1..4");
    end

    state_t            state_q, state_d;
    logic              abort_q, abort_d;
    logic              ack_q, ack_d, err_q, err_d;
    logic [DW-1:0]     dat_q, ctrl_val;
    logic              run_q, run_nxt, wr_err_q, core_rst_q;
    logic              csb0_q, web0_q, csb1_q;
    logic [DW/8-1:0]   wmask0_q;
    logic [AW-1:0]     addr0_q, addr1_q;
    logic [DW-1:0]     din0_q;
    logic              p0_go, p0_we, p1_go, ctrl_wr, ctrl_rd, set_wrerr, cap, clr_dat;
    logic              req, is_ctrl, rd_issue, rd_done, p0_run;

    assign req     = wbs_cyc_i && wbs_stb_i;
    assign is_ctrl = wbs_adr_i[CTRL_SEL];

    always_comb begin
        ctrl_val                        = '0;
        ctrl_val[CTRL_RUN]              = run_q;
        ctrl_val[CTRL_WRERR]            = wr_err_q;
        ctrl_val[CTRL_LAT_LSB +: 8]     = 8'(READ_LAT);
    end

    // A read is in flight in the single cycle its chip select is low.
    assign rd_issue = (!csb0_q && web0_q) || !csb1_q;

    sram_rd_pipe #(.READ_LAT(READ_LAT)) u_rd_pipe (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .issue    (rd_issue),
        .done     (rd_done)
    );

    always_comb begin
        state_d   = state_q;
        abort_d   = abort_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        p0_go     = 1'b0;
        p0_we     = 1'b0;
        p1_go     = 1'b0;
        ctrl_wr   = 1'b0;
        ctrl_rd   = 1'b0;
        set_wrerr = 1'b0;
        cap       = 1'b0;
        clr_dat   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (is_ctrl) begin
                        ack_d   = 1'b1;
                        ctrl_wr = wbs_we_i;
                        ctrl_rd = !wbs_we_i;
                        state_d = ST_RESP;
                    end else if (wbs_we_i) begin
                        if (run_q) begin
                            err_d     = 1'b1;
                            set_wrerr = 1'b1;
                            state_d   = ST_RESP;
                        end else if (wbs_sel_i != '0) begin
                            p0_go   = 1'b1;
                            p0_we   = 1'b1;
                            state_d = ST_MEM_WR;
                        end else begin
                            ack_d   = 1'b1;
                            state_d = ST_RESP;
                        end
                    end else begin
                        p0_go   = !run_q;
                        p1_go   = run_q;
                        abort_d = 1'b0;
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_MEM_WR: begin
                ack_d   = wbs_cyc_i;
                state_d = wbs_cyc_i ? ST_RESP : ST_IDLE;
            end
            ST_RD_WAIT: begin
                // An abort is remembered so a re-raised cyc cannot collect stale data.
                if (!wbs_cyc_i) abort_d = 1'b1;
                if (rd_done) begin
                    if (abort_d) begin
                        state_d = ST_IDLE;
                    end else begin
                        cap     = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                clr_dat = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign run_nxt = ctrl_wr ? wbs_dat_i[CTRL_RUN] : run_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            abort_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            run_q      <= RUN_RST;
            core_rst_q <= !RUN_RST;
            wr_err_q   <= 1'b0;
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            wmask0_q   <= '0;
            addr0_q    <= '0;
            din0_q     <= '0;
            csb1_q     <= 1'b1;
            addr1_q    <= '0;
        end else begin
            state_q    <= state_d;
            abort_q    <= abort_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            run_q      <= run_nxt;
            core_rst_q <= !run_nxt;
            if (set_wrerr)
                wr_err_q <= 1'b1;
            else if (ctrl_wr && wbs_dat_i[CTRL_WRERR])
                wr_err_q <= 1'b0;
            if (clr_dat)
                dat_q <= '0;
            else if (ctrl_rd)
                dat_q <= ctrl_val;
            else if (cap)
                dat_q <= run_q ? sram_dout1_i : sram_dout0_i;
            csb0_q   <= !p0_go;
            web0_q   <= !(p0_go && p0_we);
            wmask0_q <= (p0_go && p0_we) ? wbs_sel_i : '0;
            if (p0_go) addr0_q <= wbs_adr_i[AW-1:0];
            if (p0_go && p0_we) din0_q <= wbs_dat_i;
            csb1_q   <= !p1_go;
            if (p1_go) addr1_q <= wbs_adr_i[AW-1:0];
        end
    end

    // Port 0 belongs to the core in RUN; reset forces it idle regardless of RUN_RST.
    assign p0_run = run_q && !wb_rst_i;

    assign sram_csb0_o   = p0_run ? 1'b0 : csb0_q;
    assign sram_web0_o   = p0_run ? 1'b1 : web0_q;
    assign sram_wmask0_o = p0_run ? '0 : wmask0_q;
    assign sram_addr0_o  = p0_run ? core_addr_i : addr0_q;
    assign sram_din0_o   = p0_run ? '0 : din0_q;
    assign core_data_o   = p0_run ? sram_dout0_i : '0;
    assign sram_csb1_o   = csb1_q;
    assign sram_addr1_o  = addr1_q;

    assign wbs_ack_o  = ack_q;
    assign wbs_err_o  = err_q;
    assign wbs_dat_o  = dat_q;
    assign core_rst_o = core_rst_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: READ_LAT=1 instance (u1) and READ_LAT=3 instance (u3) with behavioural SRAMs.
module tb_wb_sram_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst3, cyc1, cyc3, stb, we;
    logic [3:0]  sel;
    logic [8:0]  adr;
    logic [31:0] wdat;
    logic [7:0]  core_addr;

    logic        ack1, err1, core_rst1, csb0_1, web0_1, csb1_1;
    logic [31:0] dato1, core_data1, din0_1, dout0_1, dout1_1;
    logic [3:0]  wmask0_1;
    logic [7:0]  addr0_1, addr1_1;

    logic        ack3, err3, core_rst3, csb0_3, web0_3, csb1_3;
    logic [31:0] dato3, core_data3, din0_3, dout0_3, dout1_3;
    logic [3:0]  wmask0_3;
    logic [7:0]  addr0_3, addr1_3;

    wb_sram_bridge #(.AW(8), .DW(32), .READ_LAT(1), .RUN_RST(1'b0)) u1 (
        .wb_clk_i(clk), .wb_rst_i(rst1), .wbs_cyc_i(cyc1), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack1), .wbs_err_o(err1),
        .wbs_dat_o(dato1), .core_rst_o(core_rst1), .core_addr_i(core_addr), .core_data_o(core_data1),
        .sram_csb0_o(csb0_1), .sram_web0_o(web0_1), .sram_wmask0_o(wmask0_1), .sram_addr0_o(addr0_1),
        .sram_din0_o(din0_1), .sram_dout0_i(dout0_1), .sram_csb1_o(csb1_1), .sram_addr1_o(addr1_1),
        .sram_dout1_i(dout1_1));

    wb_sram_bridge #(.AW(8), .DW(32), .READ_LAT(3), .RUN_RST(1'b0)) u3 (
        .wb_clk_i(clk), .wb_rst_i(rst3), .wbs_cyc_i(cyc3), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack3), .wbs_err_o(err3),
        .wbs_dat_o(dato3), .core_rst_o(core_rst3), .core_addr_i(core_addr), .core_data_o(core_data3),
        .sram_csb0_o(csb0_3), .sram_web0_o(web0_3), .sram_wmask0_o(wmask0_3), .sram_addr0_o(addr0_3),
        .sram_din0_o(din0_3), .sram_dout0_i(dout0_3), .sram_csb1_o(csb1_3), .sram_addr1_o(addr1_3),
        .sram_dout1_i(dout1_3));

    // Behavioural SRAMs: masked write on port 0, reads valid READ_LAT cycles after the sampling edge.
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] q0_1, q1_1;
    logic [31:0] q0_3 [3];
    logic [31:0] q1_3 [3];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!csb0_1 && !web0_1) mem1[addr0_1] <= merge(mem1[addr0_1], din0_1, wmask0_1);
        q0_1 <= (!csb0_1 && web0_1) ? mem1[addr0_1] : 'x;
        q1_1 <= !csb1_1 ? mem1[addr1_1] : 'x;
        if (!csb0_3 && !web0_3) mem3[addr0_3] <= merge(mem3[addr0_3], din0_3, wmask0_3);
        q0_3[0] <= (!csb0_3 && web0_3) ? mem3[addr0_3] : 'x;
        q1_3[0] <= !csb1_3 ? mem3[addr1_3] : 'x;
        q0_3[1] <= q0_3[0];
        q0_3[2] <= q0_3[1];
        q1_3[1] <= q1_3[0];
        q1_3[2] <= q1_3[1];
    end
    assign dout0_1 = q0_1;
    assign dout1_1 = q1_1;
    assign dout0_3 = q0_3[2];
    assign dout1_3 = q1_3[2];

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_errs   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errs++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic get_ack(input int i);  return (i == 1) ? ack1 : ack3;  endfunction
    function automatic logic get_err(input int i);  return (i == 1) ? err1 : err3;  endfunction
    function automatic logic get_csb0(input int i); return (i == 1) ? csb0_1 : csb0_3; endfunction
    function automatic logic get_web0(input int i); return (i == 1) ? web0_1 : web0_3; endfunction
    function automatic logic get_csb1(input int i); return (i == 1) ? csb1_1 : csb1_3; endfunction
    function automatic logic [3:0]  get_wm(input int i);  return (i == 1) ? wmask0_1 : wmask0_3; endfunction
    function automatic logic [31:0] get_dat(input int i); return (i == 1) ? dato1 : dato3; endfunction

    // pchk: 0 none, 1 port-0 write in c1, 2 port-0 read in c1, 3 port-1 read in c1
    task automatic wb_txn(input int inst, input logic w, input logic [8:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic exp_err, input logic [31:0] exp_dat,
                          input int exp_lat, input int pchk, input string tag);
        exp_t e;
        int n;
        logic seen, c0v, w0v, c1v;
        logic [3:0] m0v;
        sb.push_back('{exp_err, exp_dat, exp_lat});
        we = w; adr = a; sel = s; wdat = d; stb = 1'b1;
        if (inst == 1) cyc1 = 1'b1; else cyc3 = 1'b1;
        n = 0; seen = 1'b0; c0v = 1'b1; w0v = 1'b1; c1v = 1'b1; m0v = '0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (n == 1) begin
                c0v = get_csb0(inst); w0v = get_web0(inst); c1v = get_csb1(inst); m0v = get_wm(inst);
            end
            if (get_ack(inst) || get_err(inst)) seen = 1'b1;
        end
        e = sb.pop_front();
        chk({tag, "/resp_seen"}, 32'(seen), 32'd1);
        chk({tag, "/resp_cycle"}, 32'(n), 32'(e.lat));
        chk({tag, "/err"}, 32'(get_err(inst)), 32'(e.err));
        chk({tag, "/ack"}, 32'(get_ack(inst)), 32'(!e.err));
        chk({tag, "/dat"}, get_dat(inst), e.dat);
        case (pchk)
            1: begin
                chk({tag, "/csb0"}, 32'(c0v), 32'd0);
                chk({tag, "/web0"}, 32'(w0v), 32'd0);
                chk({tag, "/wmask0"}, 32'(m0v), 32'(s));
            end
            2: chk({tag, "/csb0"}, 32'(c0v), 32'd0);
            3: chk({tag, "/csb1"}, 32'(c1v), 32'd0);
            default: ;
        endcase
        cyc1 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        chk({tag, "/ack_pulse"}, 32'(get_ack(inst) | get_err(inst)), 32'd0);
        chk({tag, "/dat_clr"}, get_dat(inst), 32'd0);
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
        rst1 = 1'b1; rst3 = 1'b1;
        cyc1 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
        sel = '0; adr = '0; wdat = '0; core_addr = '0;
        tick();
        tick();
        chk("rst/csb0_1", 32'(csb0_1), 32'd1);
        chk("rst/csb1_1", 32'(csb1_1), 32'd1);
        chk("rst/web0_1", 32'(web0_1), 32'd1);
        chk("rst/ack1", 32'(ack1), 32'd0);
        chk("rst/dat1", dato1, 32'd0);
        chk("rst/core_rst1", 32'(core_rst1), 32'd1);
        chk("rst/csb0_3", 32'(csb0_3), 32'd1);
        rst1 = 1'b0; rst3 = 1'b0;
        tick();

        wb_txn(1, 1'b0, 9'h100, 4'hF, 32'h0, 1'b0, 32'h0000_0100, 1, 0, "ctrl_rd");
        chk("load/core_rst1", 32'(core_rst1), 32'd1);
        chk("load/core_data1", core_data1, 32'd0);
        wb_txn(1, 1'b1, 9'h005, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1, "wr_full");
        wb_txn(1, 1'b1, 9'h005, 4'h1, 32'h0000_00AA, 1'b0, 32'h0, 2, 1, "wr_byte");
        wb_txn(1, 1'b0, 9'h005, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEAA, 3, 2, "rd_load");
        wb_txn(1, 1'b1, 9'h006, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1, 0, "wr_sel0");
        chk("wr_sel0/mem", mem1[6], 32'h0);

        wb_txn(1, 1'b1, 9'h100, 4'hF, 32'h1, 1'b0, 32'h0, 1, 0, "ctrl_run");
        chk("run/core_rst1", 32'(core_rst1), 32'd0);
        core_addr = 8'h05;
        #1;
        chk("run/addr0", 32'(addr0_1), 32'h05);
        chk("run/csb0", 32'(csb0_1), 32'd0);
        chk("run/web0", 32'(web0_1), 32'd1);
        tick();
        chk("run/core_data", core_data1, 32'hDEAD_BEAA);
        wb_txn(1, 1'b0, 9'h005, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEAA, 3, 3, "rd_run");
        chk("run/core_data_b", core_data1, 32'hDEAD_BEAA);
        wb_txn(1, 1'b1, 9'h010, 4'hF, 32'h0000_1234, 1'b1, 32'h0, 1, 0, "wr_run_err");
        chk("wr_run_err/mem", mem1[16], 32'h0);
        wb_txn(1, 1'b0, 9'h100, 4'hF, 32'h0, 1'b0, 32'h0000_0103, 1, 0, "ctrl_wrerr");
        wb_txn(1, 1'b1, 9'h100, 4'hF, 32'h3, 1'b0, 32'h0, 1, 0, "ctrl_w1c");
        wb_txn(1, 1'b0, 9'h100, 4'hF, 32'h0, 1'b0, 32'h0000_0101, 1, 0, "ctrl_clr");

        wb_txn(3, 1'b0, 9'h100, 4'hF, 32'h0, 1'b0, 32'h0000_0300, 1, 0, "ctrl3");
        chk("lat3/core_data", core_data3, 32'd0);
        wb_txn(3, 1'b1, 9'h020, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 1, "wr3");
        wb_txn(3, 1'b0, 9'h020, 4'hF, 32'h0, 1'b0, 32'hCAFE_F00D, 5, 2, "rd3");

        we = 1'b0; adr = 9'h020; sel = 4'hF; stb = 1'b1; cyc3 = 1'b1;
        tick();
        tick();
        cyc3 = 1'b0; stb = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (ack3 || err3) seen = 1'b1;
        end
        chk("abort/no_resp", 32'(seen), 32'd0);
        wb_txn(3, 1'b0, 9'h020, 4'hF, 32'h0, 1'b0, 32'hCAFE_F00D, 5, 2, "rd3_after_abort");

        we = 1'b0; adr = 9'h020; sel = 4'hF; stb = 1'b1; cyc3 = 1'b1;
        tick();
        chk("midrst/csb0_issued", 32'(csb0_3), 32'd0);
        tick();
        rst3 = 1'b1;
        #1;
        chk("midrst/csb0", 32'(csb0_3), 32'd1);
        chk("midrst/csb1", 32'(csb1_3), 32'd1);
        chk("midrst/ack", 32'(ack3), 32'd0);
        cyc3 = 1'b0; stb = 1'b0;
        tick();
        tick();
        rst3 = 1'b0;
        tick();
        chk("midrst/core_rst", 32'(core_rst3), 32'd1);
        chk("midrst/ack_after", 32'(ack3), 32'd0);
        wb_txn(3, 1'b1, 9'h021, 4'hF, 32'h55AA_55AA, 1'b0, 32'h0, 2, 1, "wr3_post_rst");
        wb_txn(3, 1'b0, 9'h021, 4'hF, 32'h0, 1'b0, 32'h55AA_55AA, 5, 2, "rd3_post_rst");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
